axi_lite_pair: RTL and testbench

- Self-contained AXI4-Lite master plus register-file slave, connected over an internal single-beat AXI4-Lite bus.
- A simple user command port (write or read request, one-cycle ready pulse) drives the master.
- The master performs complete write (AW/W/B) and read (AR/R) transactions against the slave's word-addressed register bank.
- Used as a bus-protocol building block and as a reference endpoint for the team's AXI interconnect work.

---
 rtl/axi_lite_pkg.sv | 20 ++
 rtl/axi_lite_reg_slave.sv | 121 ++++++++++++
 rtl/axi_lite_pair.sv | 154 +++++++++++++++
 tb/tb_axi_lite_pair.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite master / register-slave pair:
// response codes, bus widths and the master state encoding.
package axi_lite_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WADDR,
        ST_WRESP,
        ST_RADDR,
        ST_RDATA,
        ST_DONE
    } mst_state_e;

endpackage

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register-file slave: DEPTH word-addressed 32-bit registers with
// byte strobes; out-of-range accesses answer SLVERR and never touch storage.
module axi_lite_reg_slave
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [DATA_W-1:0] s_wdata,
    input  logic [STRB_W-1:0] s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic              awready_q, awready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;

    logic              aw_in_range, ar_in_range;
    logic [IDX_W-1:0]  widx, ridx;

    assign aw_in_range = (s_awaddr < ADDR_W'(DEPTH));
    assign ar_in_range = (s_araddr < ADDR_W'(DEPTH));
    assign widx        = s_awaddr[IDX_W-1:0];
    assign ridx        = s_araddr[IDX_W-1:0];

    always_comb begin
        regs_d    = regs_q;
        awready_d = 1'b0;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        arready_d = 1'b0;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        // AW and W are accepted together; the guards keep the ready pulse to one cycle
        if (s_awvalid && s_wvalid && !awready_q && !bvalid_q)
            awready_d = 1'b1;

        if (awready_q && s_awvalid && s_wvalid) begin
            bvalid_d = 1'b1;
            if (aw_in_range) begin
                for (int b = 0; b < STRB_W; b++)
                    if (s_wstrb[b])
                        regs_d[widx][8*b +: 8] = s_wdata[8*b +: 8];
                bresp_d = RESP_OKAY;
            end else begin
                bresp_d = RESP_SLVERR;
            end
        end else if (bvalid_q && s_bready) begin
            bvalid_d = 1'b0;
        end

        if (s_arvalid && !arready_q && !rvalid_q)
            arready_d = 1'b1;

        if (arready_q && s_arvalid) begin
            rvalid_d = 1'b1;
            rdata_d  = ar_in_range ? regs_q[ridx] : '0;
            rresp_d  = ar_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && s_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            regs_q    <= '{default: '0};
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            regs_q    <= regs_d;
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign s_awready = awready_q;
    assign s_wready  = awready_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign s_arready = arready_q;
    assign s_rvalid  = rvalid_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;

endmodule

// File: rtl/axi_lite_pair.sv
// Command-driven AXI4-Lite master wired to an internal register-file slave.
// One transaction at a time; ready pulses once when it completes.
module axi_lite_pair #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic                           valid,
    input  logic                           read_valid,
    input  logic [ADDR_W-1:0]              aw_addr,
    input  logic [DATA_W-1:0]              w_data,
    input  logic [axi_lite_pkg::STRB_W-1:0] w_strb,
    input  logic [ADDR_W-1:0]              ar_addr,
    output logic                           ready,
    output logic [DATA_W-1:0]              rd_data,
    output logic [1:0]                     resp
);

    import axi_lite_pkg::*;

    mst_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [1:0]        resp_q, resp_d;
    logic              ready_q, ready_d;

    logic              m_awvalid, m_awready, m_wvalid, m_wready;
    logic              m_bvalid, m_bready, m_arvalid, m_arready;
    logic              m_rvalid, m_rready;
    logic [1:0]        m_bresp, m_rresp;
    logic [DATA_W-1:0] m_rdata;
    logic              aw_hs, w_hs;

    assign m_awvalid = (state_q == ST_WADDR) && !aw_done_q;
    assign m_wvalid  = (state_q == ST_WADDR) && !w_done_q;
    assign m_bready  = (state_q == ST_WRESP);
    assign m_arvalid = (state_q == ST_RADDR);
    assign m_rready  = (state_q == ST_RDATA);
    assign aw_hs     = m_awvalid && m_awready;
    assign w_hs      = m_wvalid && m_wready;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rd_data_d = rd_data_q;
        resp_d    = resp_q;
        // ready is registered off DONE, giving the four-edge command latency
        ready_d   = (state_q == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (valid) begin
                    addr_d  = aw_addr;
                    wdata_d = w_data;
                    wstrb_d = w_strb;
                    state_d = ST_WADDR;
                end else if (read_valid) begin
                    addr_d  = ar_addr;
                    state_d = ST_RADDR;
                end
            end
            ST_WADDR: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs))
                    state_d = ST_WRESP;
            end
            ST_WRESP: begin
                if (m_bvalid) begin
                    resp_d  = m_bresp;
                    state_d = ST_DONE;
                end
            end
            ST_RADDR: begin
                if (m_arready) state_d = ST_RDATA;
            end
            ST_RDATA: begin
                if (m_rvalid) begin
                    rd_data_d = m_rdata;
                    resp_d    = m_rresp;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rd_data_q <= '0;
            resp_q    <= RESP_OKAY;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rd_data_q <= rd_data_d;
            resp_q    <= resp_d;
            ready_q   <= ready_d;
        end
    end

    assign ready   = ready_q;
    assign rd_data = rd_data_q;
    assign resp    = resp_q;

    axi_lite_reg_slave #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_slave (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .s_awaddr  (addr_q),
        .s_awvalid (m_awvalid),
        .s_awready (m_awready),
        .s_wdata   (wdata_q),
        .s_wstrb   (wstrb_q),
        .s_wvalid  (m_wvalid),
        .s_wready  (m_wready),
        .s_bresp   (m_bresp),
        .s_bvalid  (m_bvalid),
        .s_bready  (m_bready),
        .s_araddr  (addr_q),
        .s_arvalid (m_arvalid),
        .s_arready (m_arready),
        .s_rdata   (m_rdata),
        .s_rresp   (m_rresp),
        .s_rvalid  (m_rvalid),
        .s_rready  (m_rready)
    );

endmodule

// File: tb/tb_axi_lite_pair.sv
// Directed bench for axi_lite_pair: a register model predicts each response,
// queued at issue time and compared when ready pulses.
module tb_axi_lite_pair;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        valid = 1'b0;
    logic        read_valid = 1'b0;
    logic [31:0] aw_addr = '0;
    logic [31:0] w_data = '0;
    logic [3:0]  w_strb = '0;
    logic [31:0] ar_addr = '0;
    logic        ready;
    logic [31:0] rd_data;
    logic [1:0]  resp;

    typedef struct {
        logic        rd;
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [8];
    int          checks = 0;
    int          errors = 0;

    axi_lite_pair #(.DATA_W(32), .ADDR_W(32), .DEPTH(8)) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .valid      (valid),
        .read_valid (read_valid),
        .aw_addr    (aw_addr),
        .w_data     (w_data),
        .w_strb     (w_strb),
        .ar_addr    (ar_addr),
        .ready      (ready),
        .rd_data    (rd_data),
        .resp       (resp)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one command (optionally with read_valid also raised), queues the
    // model's prediction, then checks latency, response and pulse width.
    task automatic txn(input bit is_rd, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input bit both, input logic [31:0] other_addr);
        exp_t e;
        exp_t got;
        int   n;
        @(negedge ACLK);
        e.rd = is_rd;
        if (is_rd) begin
            read_valid = 1'b1;
            ar_addr    = addr;
            e.resp     = (addr < 8) ? 2'b00 : 2'b10;
            e.data     = (addr < 8) ? mem[addr[2:0]] : 32'h0;
        end else begin
            valid      = 1'b1;
            aw_addr    = addr;
            w_data     = data;
            w_strb     = strb;
            if (both) begin
                read_valid = 1'b1;
                ar_addr    = other_addr;
            end
            e.resp = (addr < 8) ? 2'b00 : 2'b10;
            e.data = 32'h0;
            if (addr < 8)
                for (int b = 0; b < 4; b++)
                    if (strb[b]) mem[addr[2:0]][8*b +: 8] = data[8*b +: 8];
        end
        sb.push_back(e);
        @(posedge ACLK);
        #1;
        valid      = 1'b0;
        read_valid = 1'b0;
        n = 0;
        while (!ready && n < 20) begin
            @(posedge ACLK);
            #1;
            n++;
        end
        check(is_rd ? "rd_latency" : "wr_latency", 64'(n), 64'd4);
        if (ready && sb.size() > 0) begin
            got = sb.pop_front();
            check(got.rd ? "rd_resp" : "wr_resp", 64'(resp), 64'(got.resp));
            if (got.rd) check("rd_data", 64'(rd_data), 64'(got.data));
        end else begin
            sb.delete();
        end
        @(posedge ACLK);
        #1;
        check("ready_one_cycle", 64'(ready), 64'd0);
    endtask

    initial begin
        int hits;
        for (int i = 0; i < 8; i++) mem[i] = 32'h0;
        #1;
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_rd_data", 64'(rd_data), 64'd0);
        check("reset_resp", 64'(resp), 64'd0);
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;

        txn(1'b0, 32'd0, 32'h0000_0000, 4'b0000, 1'b0, 32'd0);
        txn(1'b1, 32'd0, 32'h0, 4'h0, 1'b0, 32'd0);
        txn(1'b0, 32'd1, 32'h1234_5678, 4'b0011, 1'b0, 32'd0);
        txn(1'b1, 32'd1, 32'h0, 4'h0, 1'b0, 32'd0);
        txn(1'b0, 32'd3, 32'h1234_5678, 4'b1101, 1'b0, 32'd0);
        txn(1'b1, 32'd3, 32'h0, 4'h0, 1'b0, 32'd0);
        txn(1'b0, 32'd7, 32'h1234_5678, 4'b1111, 1'b0, 32'd0);
        txn(1'b0, 32'd7, 32'hAABB_CCDD, 4'b0100, 1'b0, 32'd0);
        txn(1'b1, 32'd7, 32'h0, 4'h0, 1'b0, 32'd0);
        txn(1'b0, 32'd8, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'd0);
        txn(1'b1, 32'd0, 32'h0, 4'h0, 1'b0, 32'd0);
        txn(1'b1, 32'd8, 32'h0, 4'h0, 1'b0, 32'd0);

        // Simultaneous write and read request: the write must win
        txn(1'b0, 32'd2, 32'hCAFE_F00D, 4'b1111, 1'b1, 32'd5);
        txn(1'b1, 32'd2, 32'h0, 4'h0, 1'b0, 32'd0);

        // Reset while the master waits in WRESP
        @(negedge ACLK);
        valid   = 1'b1;
        aw_addr = 32'd4;
        w_data  = 32'h0000_0055;
        w_strb  = 4'b1111;
        @(posedge ACLK);
        #1;
        valid = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        ARESET = 1'b1;
        #1;
        check("async_rst_ready", 64'(ready), 64'd0);
        check("async_rst_rd_data", 64'(rd_data), 64'd0);
        check("async_rst_resp", 64'(resp), 64'd0);
        for (int i = 0; i < 8; i++) mem[i] = 32'h0;
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge ACLK);
            #1;
            if (ready) hits++;
        end
        check("no_ready_after_rst", 64'(hits), 64'd0);

        txn(1'b1, 32'd2, 32'h0, 4'h0, 1'b0, 32'd0);
        txn(1'b1, 32'd4, 32'h0, 4'h0, 1'b0, 32'd0);
        txn(1'b1, 32'd7, 32'h0, 4'h0, 1'b0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
